// File: rtl/hazard_controller.sv
// Pipeline hazard unit: load-use stalls, branch flushes, operand forwarding and a
// data-memory wait FSM with a timeout trap, plus saturating performance counters.
module hazard_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic        MemReadE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        timeout_err,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   wait_cnt, wait_cnt_n;
  logic            memwait;
  logic            loaduse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_n    = MEM_WAIT;
          wait_cnt_n = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_n    = RUN;
          wait_cnt_n = '0;
        end else if (wait_cnt == CW'(TIMEOUT)) begin
          state_n = ERROR;
        end else begin
          wait_cnt_n = wait_cnt + CW'(1);
        end
      end
      ERROR: state_n = ERROR;
      default: begin
        state_n    = RUN;
        wait_cnt_n = '0;
      end
    endcase
  end

  // Gating with reset releases every hold in the same cycle reset rises.
  always_comb begin
    memwait = 1'b0;
    if (!reset) begin
      memwait = (state == RUN && MemReqM && !MemReadyM) ||
                (state == MEM_WAIT && !MemReadyM) ||
                (state == ERROR);
    end
  end

  assign loaduse = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // A taken redirect while memory holds execute is deferred until release.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (!reset) begin
      if (memwait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (loaduse) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)
        ForwardAE = 2'b10;
      else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E)
        ForwardAE = 2'b01;
      if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)
        ForwardBE = 2'b10;
      else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E)
        ForwardBE = 2'b01;
    end
  end

  // FlushD is raised only by a redirect, so it marks exactly the flush events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err  <= 1'b0;
      stall_cycles <= 16'd0;
      flush_events <= 16'd0;
    end else begin
      timeout_err <= (state_n == ERROR);
      if (StallF && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (FlushD && flush_events != 16'hFFFF)
        flush_events <= flush_events + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller, built with TIMEOUT=4 so the
// timeout trap is reachable quickly.
module tb_hazard_controller;

  logic        clk;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        MemReadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        timeout_err;
  logic [15:0] stall_cycles, flush_events;
  logic [5:0]  ctl;

  int passed = 0;
  int total  = 0;

  localparam logic [5:0] CTL_NONE = 6'b000000;
  localparam logic [5:0] CTL_MEM  = 6'b111100;
  localparam logic [5:0] CTL_LU   = 6'b110001;
  localparam logic [5:0] CTL_BR   = 6'b000011;

  hazard_controller #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .timeout_err(timeout_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    MemReadE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    MemReadE = 1; RdE = 5; Rs1D = 5;
    RegWriteM = 1; RdM = 7; Rs1E = 7; Rs2E = 7;
    tick();
    tick();
    total++;
    if (ctl !== CTL_NONE) $display("[TB] FAIL reset_ctl: got %b expected %b", ctl, CTL_NONE);
    else passed++;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0000)
      $display("[TB] FAIL reset_fwd: got %b expected 0000", {ForwardAE, ForwardBE});
    else passed++;
    total++;
    if ({timeout_err, stall_cycles, flush_events} !== 33'd0)
      $display("[TB] FAIL reset_regs: got err=%b stall=%h flush=%h expected 0", timeout_err, stall_cycles, flush_events);
    else passed++;
    clear_inputs();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_load_use();
    do_reset();
    MemReadE = 1; RdE = 5; Rs1D = 5; Rs2D = 3;
    #1;
    total++;
    if (ctl !== CTL_LU) $display("[TB] FAIL loaduse_ctl: got %b expected %b", ctl, CTL_LU);
    else passed++;
    total++;
    if (stall_cycles !== 16'd0) $display("[TB] FAIL loaduse_cnt0: got %h expected 0000", stall_cycles);
    else passed++;
    tick();
    MemReadE = 0;
    #1;
    total++;
    if (stall_cycles !== 16'd1) $display("[TB] FAIL loaduse_cnt1: got %h expected 0001", stall_cycles);
    else passed++;
    total++;
    if (ctl !== CTL_NONE) $display("[TB] FAIL loaduse_release: got %b expected %b", ctl, CTL_NONE);
    else passed++;
    MemReadE = 1; RdE = 9; Rs1D = 1; Rs2D = 9;
    #1;
    total++;
    if (ctl !== CTL_LU) $display("[TB] FAIL loaduse_rs2: got %b expected %b", ctl, CTL_LU);
    else passed++;
    RdE = 0; Rs1D = 0; Rs2D = 0;
    #1;
    total++;
    if (ctl !== CTL_NONE) $display("[TB] FAIL loaduse_x0: got %b expected %b", ctl, CTL_NONE);
    else passed++;
    clear_inputs();
    #1;
  endtask

  task automatic test_branch_load_use();
    do_reset();
    MemReadE = 1; RdE = 5; Rs1D = 5; PCSrcE = 1;
    #1;
    total++;
    if (ctl !== CTL_BR) $display("[TB] FAIL branch_ctl: got %b expected %b", ctl, CTL_BR);
    else passed++;
    tick();
    clear_inputs();
    #1;
    total++;
    if (flush_events !== 16'd1) $display("[TB] FAIL branch_flushcnt: got %h expected 0001", flush_events);
    else passed++;
    total++;
    if (stall_cycles !== 16'd0) $display("[TB] FAIL branch_stallcnt: got %h expected 0000", stall_cycles);
    else passed++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ctl !== CTL_MEM) $display("[TB] FAIL memwait_ctl[%0d]: got %b expected %b", i, ctl, CTL_MEM);
      else passed++;
      tick();
    end
    MemReadyM = 1;
    #1;
    total++;
    if (ctl !== CTL_BR) $display("[TB] FAIL memwait_release: got %b expected %b", ctl, CTL_BR);
    else passed++;
    tick();
    clear_inputs();
    #1;
    total++;
    if (ctl !== CTL_NONE) $display("[TB] FAIL memwait_back_run: got %b expected %b", ctl, CTL_NONE);
    else passed++;
    total++;
    if ({stall_cycles, flush_events} !== {16'd3, 16'd1})
      $display("[TB] FAIL memwait_counts: got stall=%h flush=%h expected 0003 0001", stall_cycles, flush_events);
    else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    repeat (4) tick();
    total++;
    if (timeout_err !== 1'b0) $display("[TB] FAIL timeout_early: got %b expected 0", timeout_err);
    else passed++;
    tick();
    total++;
    if (timeout_err !== 1'b1) $display("[TB] FAIL timeout_set: got %b expected 1", timeout_err);
    else passed++;
    MemReqM = 0; MemReadyM = 1;
    #1;
    total++;
    if (ctl !== CTL_MEM) $display("[TB] FAIL timeout_hold: got %b expected %b", ctl, CTL_MEM);
    else passed++;
    tick();
    total++;
    if (timeout_err !== 1'b1) $display("[TB] FAIL timeout_sticky: got %b expected 1", timeout_err);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({ctl, timeout_err} !== 7'b0) $display("[TB] FAIL timeout_reset: got ctl=%b err=%b expected 0", ctl, timeout_err);
    else passed++;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({ctl, timeout_err} !== 7'b0) $display("[TB] FAIL timeout_after_reset: got ctl=%b err=%b expected 0", ctl, timeout_err);
    else passed++;
    clear_inputs();
  endtask

  task automatic test_forwarding();
    RegWriteM = 1; RdM = 7; RegWriteW = 1; RdW = 7; Rs1E = 7; Rs2E = 0;
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b1000) $display("[TB] FAIL fwd_mem_wins: got %b expected 1000", {ForwardAE, ForwardBE});
    else passed++;
    RdM = 0;
    #1;
    total++;
    if (ForwardAE !== 2'b01) $display("[TB] FAIL fwd_wb_a: got %b expected 01", ForwardAE);
    else passed++;
    RdM = 7; RegWriteM = 0; Rs2E = 7;
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0101) $display("[TB] FAIL fwd_wb_both: got %b expected 0101", {ForwardAE, ForwardBE});
    else passed++;
    RegWriteM = 1; RdM = 3; Rs2E = 3; RdW = 0; Rs1E = 0;
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0010) $display("[TB] FAIL fwd_mem_b: got %b expected 0010", {ForwardAE, ForwardBE});
    else passed++;
    clear_inputs();
    #1;
  endtask

  task automatic test_saturation();
    do_reset();
    MemReadE = 1; RdE = 5; Rs1D = 5;
    repeat (65535) @(posedge clk);
    #1;
    total++;
    if (stall_cycles !== 16'hFFFF) $display("[TB] FAIL sat_reach: got %h expected ffff", stall_cycles);
    else passed++;
    tick();
    total++;
    if (stall_cycles !== 16'hFFFF) $display("[TB] FAIL sat_hold: got %h expected ffff", stall_cycles);
    else passed++;
    clear_inputs();
    #1;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    test_forwarding();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
